// File: rtl/ram_pkg.sv
// Shared defaults and FSM state type for the byte-enable RAM with read pipeline.
package ram_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_RD_LATENCY = 1;
    localparam int unsigned CLK_PERIOD     = 10;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Fixed-latency read response pipeline: valid and data shift together, data holds when idle.
module ram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

    // Data stages load only behind a valid bit so the output keeps the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[RD_LATENCY-1];
    assign out_data  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_be_pipe.sv
// Single-port byte-enable RAM that zero-fills itself after reset or clr, with a
// RD_LATENCY-cycle read response path.
module ram_be_pipe
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    clr,
    output logic                    init_busy
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    logic                  accept;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StInit: begin
                    if (clr) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (clr) begin
                        state_q <= StInit;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StInit;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == StRun) && !clr;
    assign init_busy = (state_q == StInit);
    assign accept    = req_valid && req_ready;

    // The clear sequence and user writes share the one write port.
    always_comb begin
        if (state_q == StInit) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end else begin
            wr_en   = accept && req_write;
            wr_addr = req_addr;
            wr_data = req_wdata;
            wr_be   = req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_en   = accept && !req_write;
    assign rd_word = mem[req_addr];

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_en),
        .in_data   (rd_word),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata)
    );

endmodule

// File: tb/tb_ram_be_pipe.sv
// Bench for ram_be_pipe: latency-1 and latency-3 instances share stimulus; a
// scoreboard per instance checks response data and arrival cycle.
module tb_ram_be_pipe;
    import ram_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;

    logic          rdy1, rdy3, busy1, busy3, rv1, rv3;
    logic [DW-1:0] rd1, rd3;

    int            nvec = 0;
    int            nerr = 0;
    int            cyc = 0;
    exp_t          q1[$];
    exp_t          q3[$];
    exp_t          e1, e3;
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last3 = '0;
    logic [DW-1:0] model [DEPTH];

    ram_be_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv1), .rsp_rdata(rd1), .clr(clr), .init_busy(busy1)
    );

    ram_be_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv3), .rsp_rdata(rd3), .clr(clr), .init_busy(busy3)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard for the latency-1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            nvec++;
            if (rv1 !== 1'b0 || rd1 !== '0) begin
                nerr++;
                $display("FAIL rst_out_l1: got valid=%b data=%h, required 0/0", rv1, rd1);
            end
            last1 = '0;
        end else if (rv1) begin
            nvec++;
            if (q1.size() == 0) begin
                nerr++;
                $display("FAIL rsp_l1: got unexpected response %h at cycle %0d", rd1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (rd1 !== e1.data || cyc != e1.due) begin
                    nerr++;
                    $display("FAIL rsp_l1: got %h at cycle %0d, required %h at cycle %0d",
                             rd1, cyc, e1.data, e1.due);
                end
                last1 = e1.data;
            end
        end else begin
            nvec++;
            if (rd1 !== last1) begin
                nerr++;
                $display("FAIL hold_l1: got %h, required %h", rd1, last1);
            end
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                nerr++;
                $display("FAIL missing_l1: got no response, required %h at cycle %0d",
                         q1[0].data, q1[0].due);
                void'(q1.pop_front());
            end
        end
    end

    // Scoreboard for the latency-3 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            nvec++;
            if (rv3 !== 1'b0 || rd3 !== '0) begin
                nerr++;
                $display("FAIL rst_out_l3: got valid=%b data=%h, required 0/0", rv3, rd3);
            end
            last3 = '0;
        end else if (rv3) begin
            nvec++;
            if (q3.size() == 0) begin
                nerr++;
                $display("FAIL rsp_l3: got unexpected response %h at cycle %0d", rd3, cyc);
            end else begin
                e3 = q3.pop_front();
                if (rd3 !== e3.data || cyc != e3.due) begin
                    nerr++;
                    $display("FAIL rsp_l3: got %h at cycle %0d, required %h at cycle %0d",
                             rd3, cyc, e3.data, e3.due);
                end
                last3 = e3.data;
            end
        end else begin
            nvec++;
            if (rd3 !== last3) begin
                nerr++;
                $display("FAIL hold_l3: got %h, required %h", rd3, last3);
            end
            if (q3.size() > 0 && q3[0].due <= cyc) begin
                nerr++;
                $display("FAIL missing_l3: got no response, required %h at cycle %0d",
                         q3[0].data, q3[0].due);
                void'(q3.pop_front());
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        for (int i = 0; i < BW; i++) begin
            if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_t e;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_be    = '0;
        e.data = model[a];
        e.due  = cyc + 1;
        q1.push_back(e);
        e.due  = cyc + 3;
        q3.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            nvec++;
            if (busy1 !== 1'b1 || rdy1 !== 1'b0 || busy3 !== 1'b1 || rdy3 !== 1'b0) begin
                nerr++;
                $display("FAIL reset_init[%0d]: got busy=%b%b ready=%b%b, required busy=1 ready=0",
                         i, busy1, busy3, rdy1, rdy3);
            end
            @(posedge clk);
            #1;
        end
        nvec++;
        if (busy1 !== 1'b0 || rdy1 !== 1'b1 || busy3 !== 1'b0 || rdy3 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_run: got busy=%b%b ready=%b%b, required busy=0 ready=1",
                     busy1, busy3, rdy1, rdy3);
        end
        clear_model();
        for (int a = 0; a < DEPTH; a++) do_read(AW'(a));
        drain();
    endtask

    task automatic test_byte_enable();
        do_write(4'd3, 32'hDEADBEEF, 4'hF);
        do_write(4'd3, 32'h11223344, 4'h5);
        do_read(4'd3);
        do_write(4'd3, 32'hFFFFFFFF, 4'h0);
        do_read(4'd3);
        do_write(4'd9, 32'hCAFEF00D, 4'hA);
        do_read(4'd9);
        do_read(4'd8);
        drain();
    endtask

    task automatic test_back_to_back();
        do_write(4'd1, 32'h01010101, 4'hF);
        do_write(4'd2, 32'h02020202, 4'hF);
        do_write(4'd3, 32'h03030303, 4'hF);
        do_read(4'd1);
        do_read(4'd2);
        do_read(4'd3);
        // First latency-3 response is due in the cycle just entered.
        nvec++;
        if (rv3 !== 1'b1 || rd3 !== 32'h01010101) begin
            nerr++;
            $display("FAIL b2b_first_l3: got valid=%b data=%h, required 1/01010101", rv3, rd3);
        end
        drain();
    endtask

    task automatic test_clr();
        do_write(4'd5, 32'hA5A5A5A5, 4'hF);
        do_read(4'd5);
        clr       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd6;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        #1;
        nvec++;
        if (rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
            nerr++;
            $display("FAIL clr_ready: got ready=%b%b, required 0", rdy1, rdy3);
        end
        @(posedge clk);
        #1;
        clr       = 1'b0;
        req_valid = 1'b0;
        // A second clr inside INIT restarts the sweep: 5 cycles plus a full DEPTH.
        for (int i = 0; i < DEPTH + 5; i++) begin
            clr = (i == 4);
            nvec++;
            if (busy1 !== 1'b1 || rdy1 !== 1'b0 || busy3 !== 1'b1 || rdy3 !== 1'b0) begin
                nerr++;
                $display("FAIL clr_init[%0d]: got busy=%b%b ready=%b%b, required busy=1 ready=0",
                         i, busy1, busy3, rdy1, rdy3);
            end
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        nvec++;
        if (busy1 !== 1'b0 || rdy1 !== 1'b1) begin
            nerr++;
            $display("FAIL clr_run: got busy=%b ready=%b, required busy=0 ready=1", busy1, rdy1);
        end
        clear_model();
        do_read(4'd5);
        do_read(4'd6);
        drain();
    endtask

    task automatic test_reset_midflight();
        do_write(4'd3, 32'h5A5A5A5A, 4'hF);
        do_read(4'd3);
        // Latency-1 response has been seen; the latency-3 one is still in flight.
        #5;
        rst_n = 1'b0;
        q3.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd7;
        req_wdata = 32'hFFFFFFFF;
        req_be    = 4'hF;
        for (int i = 0; i < DEPTH; i++) begin
            nvec++;
            if (busy3 !== 1'b1 || rdy3 !== 1'b0 || rdy1 !== 1'b0) begin
                nerr++;
                $display("FAIL rerun_init[%0d]: got busy=%b ready=%b%b, required busy=1 ready=0",
                         i, busy3, rdy1, rdy3);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        nvec++;
        if (busy3 !== 1'b0 || rdy3 !== 1'b1) begin
            nerr++;
            $display("FAIL rerun_run: got busy=%b ready=%b, required busy=0 ready=1", busy3, rdy3);
        end
        clear_model();
        do_read(4'd7);
        do_read(4'd3);
        drain();
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_clr();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
